// File: rtl/pipeline_pkg.sv
// Shared types for the decode-stage hazard controller: shadow slot layout,
// memory FSM states and the bubble constant.
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              wb;
        logic              mr;
        logic              mw;
    } slot_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_e;

    localparam slot_t BUBBLE = '0;

    // A slot produces register r only if it writes back and r is not the zero register.
    function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] r);
        return s.wb && (s.dest == r) && (r != '0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Decode-stage view, memory handshake and stall/flush controls of the
// hazard controller; master = pipeline side, slave = controller.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    import pipeline_pkg::*;

    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic              id_is_branch;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic              id_mem_w_en;
    logic              br_taken;
    logic              mem_ready;
    logic              hazard_detected;
    logic              pc_freeze;
    logic              if_id_freeze;
    logic              if_id_flush;
    logic              pipe_freeze;
    logic              mem_error;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_src1, id_src2, id_two_src, id_is_branch, id_dest,
               id_wb_en, id_mem_r_en, id_mem_w_en, br_taken, mem_ready,
        input  hazard_detected, pc_freeze, if_id_freeze, if_id_flush,
               pipe_freeze, mem_error, stall_cycles
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_is_branch, id_dest,
               id_wb_en, id_mem_r_en, id_mem_w_en, br_taken, mem_ready,
        output hazard_detected, pc_freeze, if_id_freeze, if_id_flush,
               pipe_freeze, mem_error, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_compare.sv
// RAW match of one decode source against the EXE and MEM shadow slots.
// FORWARDING_EN selects the forwarding-aware match set.
module hazard_compare
    import pipeline_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              check_en,
    input  logic              is_branch,
    input  slot_t             exe_slot,
    input  slot_t             mem_slot,
    output logic              hazard
);

    logic exe_hit;
    logic mem_hit;
    logic unused_bits;

    assign exe_hit = slot_match(exe_slot, src);
    assign mem_hit = slot_match(mem_slot, src);

`ifdef FORWARDING_EN
    // Only a load in EXE outruns forwarding; branches resolve in decode and see no bypass.
    assign hazard      = check_en & ((exe_slot.mr & exe_hit) | (is_branch & (exe_hit | mem_hit)));
    assign unused_bits = ^{exe_slot.mw, mem_slot.mr, mem_slot.mw};
`else
    assign hazard      = check_en & (exe_hit | mem_hit);
    assign unused_bits = ^{exe_slot.mr, exe_slot.mw, mem_slot.mr, mem_slot.mw, is_branch};
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard controller: RAW bubbles, taken-branch flush and
// memory-wait freeze with timeout. Optional macro: FORWARDING_EN.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_controller_if.slave  hif
);
    import pipeline_pkg::*;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    slot_t            exe_q, exe_d;
    slot_t            mem_q, mem_d;
    mem_state_e       state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic haz_src1;
    logic haz_src2;
    logic hazard;
    logic mem_access;
    logic timed_out;
    logic mem_busy;
    logic stall;

    hazard_compare u_cmp_src1 (
        .src       (hif.id_src1),
        .check_en  (1'b1),
        .is_branch (hif.id_is_branch),
        .exe_slot  (exe_q),
        .mem_slot  (mem_q),
        .hazard    (haz_src1)
    );

    hazard_compare u_cmp_src2 (
        .src       (hif.id_src2),
        .check_en  (hif.id_two_src),
        .is_branch (hif.id_is_branch),
        .exe_slot  (exe_q),
        .mem_slot  (mem_q),
        .hazard    (haz_src2)
    );

    assign hazard     = haz_src1 | haz_src2;
    assign mem_access = mem_q.mr | mem_q.mw;
    assign timed_out  = (state_q == MEM_WAIT) && (tcnt_q == TW'(MEM_TIMEOUT));
    assign mem_busy   = mem_access & ~hif.mem_ready & ~timed_out;
    assign stall      = hazard | mem_busy;

    always_comb begin
        exe_d       = exe_q;
        mem_d       = mem_q;
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        mem_error_d = mem_error_q;
        stall_d     = stall_q;

        if (!mem_busy) begin
            mem_d = exe_q;
            exe_d = hazard ? BUBBLE
                           : slot_t'{hif.id_dest, hif.id_wb_en, hif.id_mem_r_en, hif.id_mem_w_en};
        end

        // A timed-out access is dropped: the pipe advances past it in the same cycle.
        case (state_q)
            MEM_IDLE: begin
                if (mem_access && !hif.mem_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (hif.mem_ready) begin
                    state_d = MEM_IDLE;
                    tcnt_d  = '0;
                end else if (timed_out) begin
                    state_d     = MEM_IDLE;
                    tcnt_d      = '0;
                    mem_error_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase

        if (stall && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q       <= BUBBLE;
            mem_q       <= BUBBLE;
            state_q     <= MEM_IDLE;
            tcnt_q      <= '0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
        end
    end

    assign hif.hazard_detected = hazard;
    assign hif.pc_freeze       = stall;
    assign hif.if_id_freeze    = stall;
    assign hif.if_id_flush     = rst & hif.br_taken & ~stall;
    assign hif.pipe_freeze     = mem_busy;
    assign hif.mem_error       = mem_error_q;
    assign hif.stall_cycles    = stall_q;

endmodule
